// File: rtl/veritune_pkg.sv
// Shared definitions for the Veritune playback path: default widths and the
// one-hot player state encoding used by the record/playback controllers.
package veritune_pkg;

  localparam int VT_ADDR_W  = 17;
  localparam int VT_DATA_W  = 16;
  localparam int VT_FRAC_W  = 4;
  localparam int RATE_UNITY = 1 << VT_FRAC_W;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_WAIT_TICK = 5'b00010,
    ST_FETCH     = 5'b00100,
    ST_READ      = 5'b01000,
    ST_END       = 5'b10000
  } player_state_e;

endpackage

// File: rtl/veritune_phase_acc.sv
// Fractional playback position: holds pos and the latched Length/Rate/Loop,
// advances by Rate and wraps once by (Length+1) samples when looping.
module veritune_phase_acc #(
  parameter int ADDR_W = 17,
  parameter int FRAC_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] length_i,
  input  logic [7:0]        rate_i,
  input  logic              loop_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              end_o
);

  localparam int POS_W = ADDR_W + 1 + FRAC_W;

  logic [POS_W-1:0]  pos_q, pos_d;
  logic [7:0]        rate_q;
  logic [ADDR_W-1:0] length_q;
  logic              loop_q;

  logic [POS_W-1:0]  sum;
  logic [POS_W-1:0]  span;
  logic [ADDR_W:0]   len_p1;
  logic              over;

  assign sum    = pos_q + POS_W'(rate_q);
  assign len_p1 = {1'b0, length_q} + (ADDR_W+1)'(1);
  assign span   = {len_p1, {FRAC_W{1'b0}}};
  assign over   = sum[POS_W-1:FRAC_W] > {1'b0, length_q};

  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = '0;
    end else if (advance_i) begin
      pos_d = (over && loop_q) ? (sum - span) : sum;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pos_q    <= '0;
      rate_q   <= 8'd1;
      length_q <= '0;
      loop_q   <= 1'b0;
    end else begin
      pos_q <= pos_d;
      if (load_i) begin
        // A zero step would stall playback forever; treat it as the smallest step.
        rate_q   <= (rate_i == 8'd0) ? 8'd1 : rate_i;
        length_q <= length_i;
        loop_q   <= loop_i;
      end
    end
  end

  assign addr_o = pos_q[FRAC_W +: ADDR_W];
  // pos has already been advanced by the time READ looks at this flag.
  assign end_o  = (pos_q[POS_W-1:FRAC_W] > {1'b0, length_q}) && !loop_q;

endmodule

// File: rtl/veritune_player.sv
// Playback reader: on each sample tick fetches the buffer at the fractional
// position and presents the sample on Audio_Out one cycle after the read.
//
// state     | meaning
// IDLE      | not playing, waiting for Start
// WAIT_TICK | playing, waiting for Sample_En
// FETCH     | read strobe to memory, position advances
// READ      | memory data presented on Audio_Out
// END       | natural end reached, Done pulse
module veritune_player
  import veritune_pkg::*;
#(
  parameter int ADDR_W = VT_ADDR_W,
  parameter int DATA_W = VT_DATA_W,
  parameter int FRAC_W = VT_FRAC_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stop,
  input  logic [ADDR_W-1:0] Length,
  input  logic [7:0]        Rate,
  input  logic              Loop,
  input  logic              Sample_En,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Audio_Out,
  output logic              Audio_Valid,
  output logic              Busy,
  output logic              Done
);

  player_state_e     state_q, state_d;
  logic [DATA_W-1:0] audio_q, audio_d;
  logic              acc_load, acc_advance;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_end;

  veritune_phase_acc #(
    .ADDR_W (ADDR_W),
    .FRAC_W (FRAC_W)
  ) u_phase_acc (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .load_i    (acc_load),
    .advance_i (acc_advance),
    .length_i  (Length),
    .rate_i    (Rate),
    .loop_i    (Loop),
    .addr_o    (acc_addr),
    .end_o     (acc_end)
  );

  always_comb begin
    state_d     = state_q;
    audio_d     = audio_q;
    acc_load    = 1'b0;
    acc_advance = 1'b0;
    Mem_Rd      = 1'b0;
    Mem_Addr    = '0;
    Audio_Out   = audio_q;
    Audio_Valid = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start && !Stop) begin
          acc_load = 1'b1;
          state_d  = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        Busy = 1'b1;
        if (Sample_En) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        Busy        = 1'b1;
        Mem_Rd      = 1'b1;
        Mem_Addr    = acc_addr;
        acc_advance = !Stop;
        state_d     = ST_READ;
      end
      ST_READ: begin
        Busy = 1'b1;
        // Data arriving in the Stop cycle belongs to an aborted read.
        if (!Stop) begin
          Audio_Out   = Mem_Data;
          Audio_Valid = 1'b1;
          audio_d     = Mem_Data;
        end
        state_d = acc_end ? ST_END : ST_WAIT_TICK;
      end
      ST_END: begin
        Done    = !Stop;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (Stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      audio_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      audio_q <= '0;
    end else begin
      state_q <= state_d;
      audio_q <= audio_d;
    end
  end

endmodule

// File: tb/tb_veritune_player.sv
// Bench for veritune_player: a sample-index/arithmetic model predicts every
// output each cycle; literal sequences pin the model for the directed cases.
module tb_veritune_player;
  import veritune_pkg::*;

  logic        clk;
  logic        Reset_n, Start, Stop, Loop, Sample_En;
  logic [16:0] Length;
  logic [7:0]  Rate;
  logic        Mem_Rd, Audio_Valid, Busy, Done;
  logic [16:0] Mem_Addr;
  logic [15:0] Mem_Data, Audio_Out;

  veritune_player dut (
    .Clk         (clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Stop        (Stop),
    .Length      (Length),
    .Rate        (Rate),
    .Loop        (Loop),
    .Sample_En   (Sample_En),
    .Mem_Rd      (Mem_Rd),
    .Mem_Addr    (Mem_Addr),
    .Mem_Data    (Mem_Data),
    .Audio_Out   (Audio_Out),
    .Audio_Valid (Audio_Valid),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:31];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'((i + 1) * 10);
    Mem_Data = '0;
  end
  always @(posedge clk)
    if (Mem_Rd) Mem_Data <= (Mem_Addr < 17'd32) ? mem[Mem_Addr[4:0]] : 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_k samples played so far; m_age is the number of cycles since the
  // tick (0 waiting, 1 read, 2 output, 3 end pulse).
  bit cmp_en = 0;
  bit m_play = 0;
  int m_age = 0, m_k = 0, m_len = 0, m_rate = 1;
  bit m_loop = 0;
  int m_hold = 0;

  function automatic int addr_of(input int k);
    int p;
    p = k * m_rate;
    if (m_loop) p = p % ((m_len + 1) * 16);
    return p / 16;
  endfunction

  always @(posedge clk) begin
    if (!Reset_n) begin
      m_play = 0; m_age = 0; m_hold = 0; cmp_en = 1;
    end else if (m_play) begin
      if (Stop) begin
        m_play = 0; m_hold = 0;
      end else begin
        case (m_age)
          0: if (Sample_En) m_age = 1;
          1: m_age = 2;
          2: begin
            m_hold = mem[addr_of(m_k)];
            m_age  = (!m_loop && ((m_k + 1) * m_rate) / 16 > m_len) ? 3 : 0;
            m_k++;
          end
          default: m_play = 0;
        endcase
      end
    end else if (Start && !Stop) begin
      m_play = 1; m_age = 0; m_k = 0;
      m_len  = int'(Length);
      m_rate = (Rate == 8'd0) ? 1 : int'(Rate);
      m_loop = Loop;
    end
  end

  int out_q[$];
  int addr_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      bit e_rd, e_valid;
      e_rd    = m_play && m_age == 1;
      e_valid = m_play && m_age == 2 && !Stop;
      check("busy",  Busy,        m_play && m_age < 3);
      check("rd",    Mem_Rd,      e_rd);
      check("addr",  Mem_Addr,    e_rd ? addr_of(m_k) : 0);
      check("valid", Audio_Valid, e_valid);
      check("audio", Audio_Out,   e_valid ? mem[addr_of(m_k)] : m_hold);
      check("done",  Done,        m_play && m_age == 3 && !Stop);
      if (Audio_Valid) out_q.push_back(int'(Audio_Out));
      if (Mem_Rd) addr_q.push_back(int'(Mem_Addr));
      if (Done) done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    out_q.delete(); addr_q.delete(); done_cnt = 0;
  endtask

  task automatic start_play(input int l, input int r, input bit lp);
    Length = 17'(l); Rate = 8'(r); Loop = lp; Start = 1'b1;
    step(1);
    Start = 1'b0;
    step(1);
  endtask

  task automatic tick();
    Sample_En = 1'b1;
    step(1);
    Sample_En = 1'b0;
    step(4);
  endtask

  task automatic check_list(input string nm, input int got[$], input int exp[$]);
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(nm, got[i], exp[i]);
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Stop = 1'b0; Loop = 1'b0;
    Sample_En = 1'b0; Length = '0; Rate = '0;
    step(2);
    Reset_n = 1'b1;
    check("rst_busy", Busy, 0);
    check("rst_rd", Mem_Rd, 0);
    check("rst_addr", Mem_Addr, 0);
    check("rst_audio", Audio_Out, 0);
    check("rst_valid", Audio_Valid, 0);
    check("rst_done", Done, 0);
    step(2);

    // 1.0x, four samples, with a Start while busy that must be ignored
    clear_log();
    start_play(3, RATE_UNITY, 0);
    tick();
    Rate = 8'd32; Start = 1'b1; step(1); Start = 1'b0; step(1);
    tick(); tick(); tick();
    step(3);
    check_list("t1_out", out_q, '{10, 20, 30, 40});
    check("t1_done", done_cnt, 1);
    check("t1_busy", Busy, 0);
    check("t1_hold", Audio_Out, 40);

    // 2.0x skips every other sample; a tick after the end is ignored
    clear_log();
    start_play(3, 32, 0);
    tick(); tick(); tick();
    check_list("t2_addr", addr_q, '{0, 2});
    check_list("t2_out", out_q, '{10, 30});
    check("t2_done", done_cnt, 1);

    // 0.5x repeats each sample
    clear_log();
    start_play(3, 8, 0);
    for (int i = 0; i < 8; i++) tick();
    step(2);
    check_list("t3_addr", addr_q, '{0, 0, 1, 1, 2, 2, 3, 3});
    check_list("t3_out", out_q, '{10, 10, 20, 20, 30, 30, 40, 40});
    check("t3_done", done_cnt, 1);

    // 5.0x looping over 16 samples
    clear_log();
    start_play(15, 80, 1);
    for (int i = 0; i < 8; i++) tick();
    check_list("t4_addr", addr_q, '{0, 5, 10, 15, 4, 9, 14, 3});
    check("t4_done", done_cnt, 0);
    check("t4_busy", Busy, 1);
    Stop = 1'b1; step(1); Stop = 1'b0;
    check("t4_stop_busy", Busy, 0);
    check("t4_stop_audio", Audio_Out, 0);
    step(2);

    // Stop during the read of address 2
    clear_log();
    start_play(3, RATE_UNITY, 0);
    tick(); tick();
    Sample_En = 1'b1; step(1);
    Sample_En = 1'b0; step(1);
    Stop = 1'b1; step(1);
    Stop = 1'b0;
    check("t5_audio", Audio_Out, 0);
    check("t5_busy", Busy, 0);
    step(3);
    check_list("t5_out", out_q, '{10, 20});
    check_list("t5_addr", addr_q, '{0, 1, 2});
    check("t5_done", done_cnt, 0);

    // Length 0: a single sample, then done
    clear_log();
    start_play(0, RATE_UNITY, 0);
    tick(); tick();
    check_list("t6_out", out_q, '{10});
    check("t6_done", done_cnt, 1);

    // Rate 0 behaves as the smallest step: index 0 sixteen times
    clear_log();
    start_play(0, 0, 0);
    for (int i = 0; i < 17; i++) tick();
    check("t7_reads", addr_q.size(), 16);
    check("t7_done", done_cnt, 1);

    // Reset mid-playback coinciding with a tick, then Start+Stop together
    clear_log();
    start_play(3, RATE_UNITY, 0);
    tick();
    Sample_En = 1'b1; Reset_n = 1'b0; step(1);
    Sample_En = 1'b0; Reset_n = 1'b1;
    check("t8_busy", Busy, 0);
    check("t8_rd", Mem_Rd, 0);
    check("t8_audio", Audio_Out, 0);
    check("t8_done", Done, 0);
    Start = 1'b1; Stop = 1'b1; step(1);
    Start = 1'b0; Stop = 1'b0;
    check("t8_idle_busy", Busy, 0);
    tick();
    check("t8_reads", addr_q.size(), 1);
    check("t8_outs", out_q.size(), 1);
    check("t8_busy_end", Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
